// File: rtl/cmd_decoder_if.sv
// DDR4 command/address pin bundle driven by the controller (master) into cmd_decoder (slave).
// No valid/ready handshake: every pin is sampled on each rising clk, and cs_n=0 qualifies a command.
interface cmd_decoder_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 14
);
  logic                 cke;
  logic                 cs_n;
  logic                 act_n;
  logic                 ras_n;
  logic                 cas_n;
  logic                 we_n;
  logic [BGWIDTH-1:0]   bg_i;
  logic [BAWIDTH-1:0]   ba_i;
  logic [ADDRWIDTH-1:0] addr_i;
  logic                 par;

  modport master (output cke, cs_n, act_n, ras_n, cas_n, we_n, bg_i, ba_i, addr_i, par);
  modport slave  (input  cke, cs_n, act_n, ras_n, cas_n, we_n, bg_i, ba_i, addr_i, par);
endinterface

// File: rtl/cmd_decoder.sv
// DDR4 command decoder: one-hot command pulses, CKE power FSM, per-bank open-row table.
// Optional command/address parity check and alert_n pulse when CMD_PARITY_EN is defined.
module cmd_decoder #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 14,
  parameter int ALERTCYC  = 6,
  localparam int NBANKS   = 2 ** (BGWIDTH + BAWIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  cmd_decoder_if.slave                      pins,
  output logic [BGWIDTH-1:0]                bg,
  output logic [BAWIDTH-1:0]                ba,
  output logic [ADDRWIDTH-1:0]              addr,
  output logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW,
  output logic PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA,
  output logic [NBANKS-1:0]                 row_open,
  output logic [NBANKS-1:0][ADDRWIDTH-1:0]  open_row,
  output logic                              illegal,
  output logic [7:0]                        err_cnt,
  output logic                              alert_n,
  output logic [1:0]                        pwr_state
);
  typedef enum logic [1:0] {PWR_ON = 2'd0, PWR_PWRDN = 2'd1, PWR_SELFREF = 2'd2} pwr_t;

  localparam int I_ACT = 18, I_BST = 17, I_CFG = 16, I_CKEH = 15, I_CKEL = 14, I_DPD = 13;
  localparam int I_DPDX = 12, I_MRR = 11, I_MRW = 10, I_PD = 9, I_PDX = 8, I_PR = 7, I_PRA = 6;
  localparam int I_RD = 5, I_RDA = 4, I_REF = 3, I_SRF = 2, I_WR = 1, I_WRA = 0;

  pwr_t                             pwr_q, pwr_d;
  logic                             cke_q;
  logic [18:0]                      pulse_q, pulse_d;
  logic                             illegal_d, par_err, err_inc, cap;
  logic [NBANKS-1:0]                row_open_d;
  logic [NBANKS-1:0][ADDRWIDTH-1:0] open_row_d;
  logic [BGWIDTH+BAWIDTH-1:0]       bank;
  logic [2:0]                       rcw;
  logic                             is_nop, is_ref, any_open, par_bad;

  assign bank     = {pins.bg_i, pins.ba_i};
  assign rcw      = {pins.ras_n, pins.cas_n, pins.we_n};
  assign is_nop   = pins.cs_n | (pins.act_n & ((rcw == 3'b111) | (rcw == 3'b011)));
  assign is_ref   = ~pins.cs_n & pins.act_n & (rcw == 3'b001);
  assign any_open = |row_open;

  always_comb begin
    pwr_d      = pwr_q;
    pulse_d    = '0;
    illegal_d  = 1'b0;
    par_err    = 1'b0;
    cap        = 1'b0;
    row_open_d = row_open;
    open_row_d = open_row;
    case (pwr_q)
      PWR_ON: begin
        if (cke_q && !pins.cke) begin
          // cke falling: a clean REF enters self-refresh, anything else powers down
          pulse_d[I_CKEL] = 1'b1;
          if (is_ref && !any_open) begin
            pulse_d[I_SRF] = 1'b1;
            pwr_d          = PWR_SELFREF;
          end else begin
            pulse_d[I_PD] = 1'b1;
            pwr_d         = PWR_PWRDN;
            illegal_d     = ~is_nop;
          end
        end else if (cke_q && pins.cke && !pins.cs_n) begin
          if (par_bad) begin
            par_err = 1'b1;
          end else if (!pins.act_n) begin
            if (row_open[bank]) illegal_d = 1'b1;
            else begin
              pulse_d[I_ACT]   = 1'b1;
              row_open_d[bank] = 1'b1;
              open_row_d[bank] = pins.addr_i;
              cap              = 1'b1;
            end
          end else begin
            case (rcw)
              3'b000, 3'b110: begin
                if (any_open) illegal_d = 1'b1;
                else begin
                  pulse_d[(rcw == 3'b000) ? I_MRW : I_CFG] = 1'b1;
                  cap = 1'b1;
                end
              end
              3'b001: begin
                if (any_open) illegal_d = 1'b1;
                else pulse_d[I_REF] = 1'b1;
              end
              3'b010: begin
                cap = 1'b1;
                if (pins.addr_i[10]) begin
                  pulse_d[I_PRA] = 1'b1;
                  row_open_d     = '0;
                end else begin
                  pulse_d[I_PR]    = 1'b1;
                  row_open_d[bank] = 1'b0;
                end
              end
              3'b100, 3'b101: begin
                if (!row_open[bank]) illegal_d = 1'b1;
                else begin
                  cap = 1'b1;
                  // auto-precharge closes the row immediately
                  if (pins.addr_i[10]) begin
                    pulse_d[(rcw == 3'b100) ? I_WRA : I_RDA] = 1'b1;
                    row_open_d[bank] = 1'b0;
                  end else begin
                    pulse_d[(rcw == 3'b100) ? I_WR : I_RD] = 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
      PWR_PWRDN: begin
        if (!cke_q && pins.cke) begin
          pulse_d[I_PDX]  = 1'b1;
          pulse_d[I_CKEH] = 1'b1;
          pwr_d           = PWR_ON;
        end
      end
      PWR_SELFREF: begin
        if (!cke_q && pins.cke) begin
          pulse_d[I_CKEH] = 1'b1;
          pwr_d           = PWR_ON;
        end
      end
      default: pwr_d = PWR_ON;
    endcase
    err_inc = illegal_d | par_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_q    <= PWR_ON;
      cke_q    <= 1'b1;
      pulse_q  <= '0;
      illegal  <= 1'b0;
      row_open <= '0;
      open_row <= '0;
      bg       <= '0;
      ba       <= '0;
      addr     <= '0;
      err_cnt  <= '0;
    end else begin
      pwr_q    <= pwr_d;
      cke_q    <= pins.cke;
      pulse_q  <= pulse_d;
      illegal  <= illegal_d;
      row_open <= row_open_d;
      open_row <= open_row_d;
      if (cap) begin
        bg   <= pins.bg_i;
        ba   <= pins.ba_i;
        addr <= pins.addr_i;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef CMD_PARITY_EN
  localparam int ACW = $clog2(ALERTCYC + 1);
  logic [ACW-1:0] alert_cnt;

  assign par_bad = (^{pins.act_n, pins.ras_n, pins.cas_n, pins.we_n,
                      pins.bg_i, pins.ba_i, pins.addr_i, pins.par}) & ~is_nop;
  assign alert_n = (alert_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                alert_cnt <= '0;
    else if (par_err)       alert_cnt <= ACW'(ALERTCYC);
    else if (alert_cnt != 0) alert_cnt <= alert_cnt - ACW'(1);
  end
`else
  logic unused_par;
  assign unused_par = pins.par;
  assign par_bad    = 1'b0;
  assign alert_n    = 1'b1;
`endif

  assign pwr_state = pwr_q;
  assign {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD,
          PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA} = pulse_q;
endmodule

// File: tb/tb_cmd_decoder.sv
// Directed-vector bench for cmd_decoder; the parity section is active when CMD_PARITY_EN is defined.
module tb_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_decoder_if #(.BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(14)) pins ();

  logic [1:0]        bg, ba;
  logic [13:0]       addr;
  logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA;
  logic [15:0]       row_open;
  logic [15:0][13:0] open_row;
  logic              illegal, alert_n;
  logic [7:0]        err_cnt;
  logic [1:0]        pwr_state;
  logic [18:0]       pulses;

  assign pulses = {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD,
                   PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA};

  localparam logic [18:0] P_ACT = 19'd1 << 18, P_CFG = 19'd1 << 16, P_CKEH = 19'd1 << 15;
  localparam logic [18:0] P_CKEL = 19'd1 << 14, P_MRW = 19'd1 << 10, P_PD = 19'd1 << 9;
  localparam logic [18:0] P_PDX = 19'd1 << 8, P_PR = 19'd1 << 7, P_PRA = 19'd1 << 6;
  localparam logic [18:0] P_RDA = 19'd1 << 4, P_REF = 19'd1 << 3;
  localparam logic [18:0] P_SRF = 19'd1 << 2, P_WR = 19'd1 << 1, P_WRA = 19'd1 << 0;

  cmd_decoder dut (
    .clk(clk), .rst(rst), .pins(pins.slave),
    .bg(bg), .ba(ba), .addr(addr),
    .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD), .DPDX(DPDX),
    .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA),
    .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA),
    .row_open(row_open), .open_row(open_row), .illegal(illegal), .err_cnt(err_cnt),
    .alert_n(alert_n), .pwr_state(pwr_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command at the falling edge; return 1 ns after the sampling edge.
  task automatic cmd(input logic ck, input logic actn, input logic [2:0] rcw,
                     input logic [1:0] g, input logic [1:0] a, input logic [13:0] ad,
                     input logic bad_par = 1'b0);
    @(negedge clk);
    pins.cke    = ck;
    pins.cs_n   = 1'b0;
    pins.act_n  = actn;
    {pins.ras_n, pins.cas_n, pins.we_n} = rcw;
    pins.bg_i   = g;
    pins.ba_i   = a;
    pins.addr_i = ad;
    pins.par    = (^{actn, rcw, g, a, ad}) ^ bad_par;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic ck);
    cmd(ck, 1'b1, 3'b111, 2'd0, 2'd0, 14'd0);
  endtask

  initial begin
    pins.cke = 1'b1; pins.cs_n = 1'b1; pins.act_n = 1'b1;
    pins.ras_n = 1'b1; pins.cas_n = 1'b1; pins.we_n = 1'b1;
    pins.bg_i = '0; pins.ba_i = '0; pins.addr_i = '0; pins.par = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pulses", 32'(pulses), 0);
    check("rst_row_open", 32'(row_open), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_alert_n", 32'(alert_n), 1);
    check("rst_bgbaaddr", {bg, ba, addr}, 0);
    check("rst_pwr", 32'(pwr_state), 0);
    @(negedge clk) rst = 1'b0;
    nop(1'b1);
    nop(1'b1);
    check("nop_pulses", 32'(pulses), 0);

    // ACT bank {1,2}=6 row 0x1A5, then auto-precharge read
    cmd(1'b1, 1'b0, 3'b111, 2'd1, 2'd2, 14'h1A5);
    check("act_pulse", 32'(pulses), 32'(P_ACT));
    check("act_bgba", {bg, ba}, {2'd1, 2'd2});
    check("act_addr", 32'(addr), 32'h1A5);
    check("act_row_open", 32'(row_open), 32'h0040);
    check("act_open_row6", 32'(open_row[6]), 32'h1A5);
    cmd(1'b1, 1'b1, 3'b101, 2'd1, 2'd2, 14'h410);
    check("rda_pulse", 32'(pulses), 32'(P_RDA));
    check("rda_row_open", 32'(row_open), 0);

    // illegal commands
    cmd(1'b1, 1'b1, 3'b101, 2'd0, 2'd3, 14'h010);
    check("rd_closed_pulse", 32'(pulses), 0);
    check("rd_closed_illegal", 32'(illegal), 1);
    check("rd_closed_err", 32'(err_cnt), 1);
    cmd(1'b1, 1'b0, 3'b111, 2'd0, 2'd0, 14'h022);
    check("act0_pulse", 32'(pulses), 32'(P_ACT));
    check("act0_illegal", 32'(illegal), 0);
    cmd(1'b1, 1'b0, 3'b111, 2'd0, 2'd0, 14'h099);
    check("act0_again_pulse", 32'(pulses), 0);
    check("act0_again_illegal", 32'(illegal), 1);
    check("act0_again_err", 32'(err_cnt), 2);
    check("act0_again_row", 32'(open_row[0]), 32'h022);

    // two banks open, precharge all, refresh
    cmd(1'b1, 1'b0, 3'b111, 2'd1, 2'd1, 14'h033);
    check("act5_row_open", 32'(row_open), 32'h0021);
    cmd(1'b1, 1'b1, 3'b010, 2'd0, 2'd0, 14'h400);
    check("pra_pulse", 32'(pulses), 32'(P_PRA));
    check("pra_row_open", 32'(row_open), 0);
    cmd(1'b1, 1'b1, 3'b001, 2'd0, 2'd0, 14'h000);
    check("ref_pulse", 32'(pulses), 32'(P_REF));
    check("ref_illegal", 32'(illegal), 0);
    check("ref_err", 32'(err_cnt), 2);

    // PR to closed bank is legal; MRW needs all banks closed; WR keeps row, WRA closes it
    cmd(1'b1, 1'b1, 3'b010, 2'd1, 2'd0, 14'h000);
    check("pr_closed_pulse", 32'(pulses), 32'(P_PR));
    check("pr_closed_illegal", 32'(illegal), 0);
    cmd(1'b1, 1'b0, 3'b111, 2'd0, 2'd2, 14'h2AB);
    cmd(1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 14'h001);
    check("mrw_open_pulse", 32'(pulses), 0);
    check("mrw_open_err", 32'(err_cnt), 3);
    cmd(1'b1, 1'b1, 3'b100, 2'd0, 2'd2, 14'h008);
    check("wr_pulse", 32'(pulses), 32'(P_WR));
    check("wr_row_open", 32'(row_open), 32'h0004);
    cmd(1'b1, 1'b1, 3'b100, 2'd0, 2'd2, 14'h408);
    check("wra_pulse", 32'(pulses), 32'(P_WRA));
    check("wra_row_open", 32'(row_open), 0);
    cmd(1'b1, 1'b1, 3'b110, 2'd0, 2'd0, 14'h005);
    check("cfg_pulse", 32'(pulses), 32'(P_CFG));
    cmd(1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 14'h001);
    check("mrw_closed_pulse", 32'(pulses), 32'(P_MRW));

    // self-refresh entry/exit
    cmd(1'b0, 1'b1, 3'b001, 2'd0, 2'd0, 14'h000);
    check("srf_pulse", 32'(pulses), 32'(P_SRF | P_CKEL));
    check("srf_pwr", 32'(pwr_state), 2);
    cmd(1'b0, 1'b0, 3'b111, 2'd0, 2'd1, 14'h111);
    check("srf_act_ignored", 32'(pulses), 0);
    check("srf_row_open", 32'(row_open), 0);
    nop(1'b1);
    check("srf_exit_pulse", 32'(pulses), 32'(P_CKEH));
    check("srf_exit_pwr", 32'(pwr_state), 0);
    nop(1'b1);
    check("on_nop_pulse", 32'(pulses), 0);

    // power-down entry/exit
    nop(1'b0);
    check("pd_pulse", 32'(pulses), 32'(P_PD | P_CKEL));
    check("pd_pwr", 32'(pwr_state), 1);
    nop(1'b0);
    check("pd_hold_pulse", 32'(pulses), 0);
    nop(1'b1);
    check("pdx_pulse", 32'(pulses), 32'(P_PDX | P_CKEH));
    nop(1'b1);

    // error counter saturation
    for (int i = 0; i < 260; i++) cmd(1'b1, 1'b1, 3'b101, 2'd3, 2'd3, 14'h000);
    check("err_saturate", 32'(err_cnt), 255);

    // asynchronous reset mid-operation
    cmd(1'b1, 1'b0, 3'b111, 2'd1, 2'd3, 14'h077);
    check("act7_row_open", 32'(row_open), 32'h0080);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_row_open", 32'(row_open), 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    check("arst_pulses", 32'(pulses), 0);
    check("arst_open_row7", 32'(open_row[7]), 0);
    pins.cs_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    nop(1'b1);

`ifdef CMD_PARITY_EN
    begin
      int lows;
      cmd(1'b1, 1'b0, 3'b111, 2'd0, 2'd2, 14'h055, 1'b1);
      check("par_act_pulse", 32'(pulses), 0);
      check("par_row_open", 32'(row_open), 0);
      check("par_illegal", 32'(illegal), 0);
      check("par_err_cnt", 32'(err_cnt), 1);
      lows = (alert_n == 1'b0) ? 1 : 0;
      for (int i = 0; i < 9; i++) begin
        nop(1'b1);
        if (alert_n == 1'b0) lows++;
      end
      check("par_alert_len", 32'(lows), 6);
      check("par_alert_end", 32'(alert_n), 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
